// File: rtl/mem_stage_ctrl_if.sv
// Bundle between the memory stage and its neighbours: EX/MEM fields in, dcache handshake,
// MEM/WB fields and status out.
interface mem_stage_ctrl_if;
  logic        mm_RegWEN;
  logic [1:0]  mm_MemtoReg;
  logic        mm_dREN;
  logic        mm_dWEN;
  logic        mm_halt;
  logic [4:0]  mm_rd;
  logic [31:0] mm_ALUOut;
  logic [31:0] mm_store;
  logic [31:0] mm_npc;
  logic [31:0] mm_instr;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        mem_busy;
  logic        wb_RegWEN;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdat;
  logic [31:0] wb_instr;
  logic        halt;
  logic        mem_timeout;

  modport master (
    output mm_RegWEN, mm_MemtoReg, mm_dREN, mm_dWEN, mm_halt, mm_rd,
           mm_ALUOut, mm_store, mm_npc, mm_instr, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy,
           wb_RegWEN, wb_rd, wb_wdat, wb_instr, halt, mem_timeout
  );

  modport slave (
    input  mm_RegWEN, mm_MemtoReg, mm_dREN, mm_dWEN, mm_halt, mm_rd,
           mm_ALUOut, mm_store, mm_npc, mm_instr, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy,
           wb_RegWEN, wb_rd, wb_wdat, wb_instr, halt, mem_timeout
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage + MEM/WB latch: registered dcache request held until dhit, stall, sticky halt.
// Optional request timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            CLK,
  input logic            RST,
  mem_stage_ctrl_if.slave bus
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_reg;
  logic        ren_reg;
  logic        wen_reg;
  logic [31:0] addr_reg;
  logic [31:0] store_reg;
  logic [31:0] ldat_reg;
  logic        halt_reg;
  logic        wb_regwen_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_wdat_reg;
  logic [31:0] wb_instr_reg;

  logic        access;
  logic        expire;
  logic        busy;
  logic        wb_load;
  logic [31:0] load_data;
  logic [31:0] wdat_next;

  assign access = (bus.mm_dREN | bus.mm_dWEN) & ~halt_reg;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_reg;
  logic       timeout_reg;

  // Expiry is taken in the REQ cycle whose miss would bring the count to TIMEOUT_CYCLES,
  // so the stalled instruction drains through WB in that same cycle.
  assign expire = (state_reg == REQ) & ~bus.dhit & (cnt_reg == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && access)
        cnt_reg <= '0;
      else if (state_reg == REQ && !bus.dhit)
        cnt_reg <= cnt_reg + 8'd1;
      if (expire)
        timeout_reg <= 1'b1;
    end
  end

  assign bus.mem_timeout = timeout_reg;
`else
  assign expire          = 1'b0;
  assign bus.mem_timeout = 1'b0;
`endif

  always_comb begin
    busy = 1'b0;
    case (state_reg)
      IDLE:    busy = access;
      REQ:     busy = ~bus.dhit & ~expire;
      default: busy = 1'b0;
    endcase
  end

  assign wb_load = ~busy & ~halt_reg;

  // The dhit cycle forwards the fresh load data; ldat only covers later use of the same fields.
  assign load_data = (state_reg == REQ && bus.dhit) ? bus.dmemload : ldat_reg;

  always_comb begin
    wdat_next = bus.mm_ALUOut;
    case (bus.mm_MemtoReg)
      2'd1:    wdat_next = load_data;
      2'd2:    wdat_next = bus.mm_npc;
      default: wdat_next = bus.mm_ALUOut;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      ren_reg       <= 1'b0;
      wen_reg       <= 1'b0;
      addr_reg      <= '0;
      store_reg     <= '0;
      ldat_reg      <= '0;
      halt_reg      <= 1'b0;
      wb_regwen_reg <= 1'b0;
      wb_rd_reg     <= '0;
      wb_wdat_reg   <= '0;
      wb_instr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            state_reg <= REQ;
            ren_reg   <= bus.mm_dREN & ~bus.mm_dWEN;
            wen_reg   <= bus.mm_dWEN;
            addr_reg  <= {bus.mm_ALUOut[31:2], 2'b00};
            store_reg <= bus.mm_store;
          end
        end
        REQ: begin
          if (bus.dhit || expire) begin
            state_reg <= IDLE;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
            addr_reg  <= '0;
            store_reg <= '0;
          end
          if (bus.dhit)
            ldat_reg <= bus.dmemload;
        end
        default: state_reg <= IDLE;
      endcase

      if (bus.mm_halt && !busy)
        halt_reg <= 1'b1;

      // Holding keeps the fields but drops the write enable so a register is written once.
      if (wb_load) begin
        wb_regwen_reg <= bus.mm_RegWEN & ~expire;
        wb_rd_reg     <= bus.mm_rd;
        wb_wdat_reg   <= wdat_next;
        wb_instr_reg  <= bus.mm_instr;
      end else begin
        wb_regwen_reg <= 1'b0;
      end
    end
  end

  assign bus.dmemREN   = ren_reg;
  assign bus.dmemWEN   = wen_reg;
  assign bus.dmemaddr  = addr_reg;
  assign bus.dmemstore = store_reg;
  assign bus.mem_busy  = busy;
  assign bus.halt      = halt_reg;
  assign bus.wb_RegWEN = wb_regwen_reg;
  assign bus.wb_rd     = wb_rd_reg;
  assign bus.wb_wdat   = wb_wdat_reg;
  assign bus.wb_instr  = wb_instr_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table for single-cycle ops plus memory,
// reset-in-REQ, halt and (with MEM_TIMEOUT_EN) timeout sequences.
module tb_mem_stage_ctrl;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        regwen;
    logic [1:0]  m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        exp_regwen;
    logic [31:0] exp_wdat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop_inputs();
    bus.mm_RegWEN   = 1'b0;
    bus.mm_MemtoReg = 2'd0;
    bus.mm_dREN     = 1'b0;
    bus.mm_dWEN     = 1'b0;
    bus.mm_halt     = 1'b0;
    bus.mm_rd       = 5'd0;
    bus.mm_ALUOut   = 32'h0;
    bus.mm_store    = 32'h0;
    bus.mm_npc      = 32'h0;
    bus.mm_instr    = 32'h0;
    bus.dhit        = 1'b0;
    bus.dmemload    = 32'h0;
  endtask

  // Runs one memory access; dhit is raised in cycle hit_k (cycle 0 is the IDLE cycle).
  task automatic mem_op(input string name, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] store,
                        input int hit_k, input logic [31:0] load,
                        input int exp_busy, input int exp_ren, input int exp_wen,
                        input logic [31:0] exp_addr, input logic [31:0] exp_store);
    int          nbusy = 0;
    int          nren = 0;
    int          nwen = 0;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_store = '0;
    bit          done = 1'b0;
    bus.mm_dREN   = ren;
    bus.mm_dWEN   = wen;
    bus.mm_ALUOut = addr;
    bus.mm_store  = store;
    for (int k = 0; k < 40 && !done; k++) begin
      bus.dhit     = (k == hit_k);
      bus.dmemload = (k == hit_k) ? load : 32'h0;
      #2;
      if (bus.mem_busy) nbusy++;
      else done = 1'b1;
      if (bus.dmemREN) nren++;
      if (bus.dmemWEN) nwen++;
      if (bus.dmemREN || bus.dmemWEN) begin
        seen_addr  = bus.dmemaddr;
        seen_store = bus.dmemstore;
      end
      step();
    end
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    check({name, " completed"}, 32'(done), 32'd1);
    check({name, " busy_cycles"}, nbusy, exp_busy);
    check({name, " ren_cycles"}, nren, exp_ren);
    check({name, " wen_cycles"}, nwen, exp_wen);
    check({name, " dmemaddr"}, seen_addr, exp_addr);
    check({name, " dmemstore"}, seen_store, exp_store);
    $display("%s: busy=%0d ren=%0d wen=%0d addr=%h store=%h", name, nbusy, nren, nwen,
             seen_addr, seen_store);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 2'd0, 5'd5,  32'h0000_1234, 32'h0000_0008, 32'h00A0_0293, 1'b1, 32'h0000_1234};
    vecs[1] = '{1'b1, 2'd2, 5'd31, 32'h0000_0999, 32'h0000_0044, 32'h0440_00EF, 1'b1, 32'h0000_0044};
    vecs[2] = '{1'b1, 2'd3, 5'd3,  32'hCAFE_0000, 32'h0000_0004, 32'h1111_2222, 1'b1, 32'hCAFE_0000};
    vecs[3] = '{1'b0, 2'd0, 5'd12, 32'h0000_0077, 32'h0000_0000, 32'h3333_4444, 1'b0, 32'h0000_0077};
    vecs[4] = '{1'b1, 2'd1, 5'd4,  32'h0000_0088, 32'h0000_0000, 32'h5555_6666, 1'b1, 32'h0000_0000};

    nop_inputs();
    RST = 1'b1;
    step();
    step();
    check("reset wb_RegWEN", 32'(bus.wb_RegWEN), 32'd0);
    check("reset wb_rd", 32'(bus.wb_rd), 32'd0);
    check("reset wb_wdat", bus.wb_wdat, 32'h0);
    check("reset wb_instr", bus.wb_instr, 32'h0);
    check("reset dmemREN", 32'(bus.dmemREN), 32'd0);
    check("reset dmemWEN", 32'(bus.dmemWEN), 32'd0);
    check("reset dmemaddr", bus.dmemaddr, 32'h0);
    check("reset halt", 32'(bus.halt), 32'd0);
    check("reset mem_timeout", 32'(bus.mem_timeout), 32'd0);
    check("reset mem_busy", 32'(bus.mem_busy), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 5; i++) begin
      bus.mm_RegWEN   = vecs[i].regwen;
      bus.mm_MemtoReg = vecs[i].m2r;
      bus.mm_rd       = vecs[i].rd;
      bus.mm_ALUOut   = vecs[i].alu;
      bus.mm_npc      = vecs[i].npc;
      bus.mm_instr    = vecs[i].instr;
      #2;
      check($sformatf("vec%0d mem_busy", i), 32'(bus.mem_busy), 32'd0);
      step();
      check($sformatf("vec%0d wb_RegWEN", i), 32'(bus.wb_RegWEN), 32'(vecs[i].exp_regwen));
      check($sformatf("vec%0d wb_rd", i), 32'(bus.wb_rd), 32'(vecs[i].rd));
      check($sformatf("vec%0d wb_wdat", i), bus.wb_wdat, vecs[i].exp_wdat);
      check($sformatf("vec%0d wb_instr", i), bus.wb_instr, vecs[i].instr);
      $display("vec%0d: wb_RegWEN=%0b wb_rd=%0d wb_wdat=%h", i, bus.wb_RegWEN, bus.wb_rd,
               bus.wb_wdat);
    end

    // Load with dhit three cycles after entering REQ.
    nop_inputs();
    bus.mm_RegWEN   = 1'b1;
    bus.mm_MemtoReg = 2'd1;
    bus.mm_rd       = 5'd7;
    bus.mm_instr    = 32'h0000_A003;
    mem_op("load", 1'b1, 1'b0, 32'h0000_0103, 32'h0, 4, 32'hDEAD_BEEF, 4, 4, 0,
           32'h0000_0100, 32'h0);
    check("load wb_RegWEN", 32'(bus.wb_RegWEN), 32'd1);
    check("load wb_rd", 32'(bus.wb_rd), 32'd7);
    check("load wb_wdat", bus.wb_wdat, 32'hDEAD_BEEF);
    check("load dmemREN after", 32'(bus.dmemREN), 32'd0);
    nop_inputs();
    step();
    check("load single write", 32'(bus.wb_RegWEN), 32'd0);

    // Store completing in the first REQ cycle.
    bus.mm_instr = 32'h0000_B023;
    mem_op("store", 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 1, 32'h0, 1, 0, 1,
           32'h0000_0040, 32'hA5A5_A5A5);
    check("store wb_RegWEN", 32'(bus.wb_RegWEN), 32'd0);
    check("store dmemWEN after", 32'(bus.dmemWEN), 32'd0);

    // Both enables set behaves as a store.
    nop_inputs();
    mem_op("both", 1'b1, 1'b1, 32'h0000_0087, 32'h0BAD_F00D, 2, 32'h0, 2, 0, 2,
           32'h0000_0084, 32'h0BAD_F00D);

    // Reset while a request is outstanding.
    nop_inputs();
    bus.mm_RegWEN   = 1'b1;
    bus.mm_MemtoReg = 2'd1;
    bus.mm_rd       = 5'd9;
    bus.mm_dREN     = 1'b1;
    bus.mm_ALUOut   = 32'h0000_0300;
    step();
    check("rstreq dmemREN in REQ", 32'(bus.dmemREN), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    nop_inputs();
    #2;
    check("rstreq dmemREN dropped", 32'(bus.dmemREN), 32'd0);
    check("rstreq wb_RegWEN", 32'(bus.wb_RegWEN), 32'd0);
    check("rstreq mem_busy", 32'(bus.mem_busy), 32'd0);
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h1111_1111;
    #1;
    check("idle dhit mem_busy", 32'(bus.mem_busy), 32'd0);
    step();
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    check("idle dhit dmemREN", 32'(bus.dmemREN), 32'd0);
    bus.mm_RegWEN   = 1'b1;
    bus.mm_MemtoReg = 2'd1;
    bus.mm_rd       = 5'd2;
    step();
    check("idle dhit ldat unchanged", bus.wb_wdat, 32'h0);
    $display("rstreq: wb_wdat=%h dmemREN=%0b", bus.wb_wdat, bus.dmemREN);

    // Halt, then a load in the next slot must never issue.
    nop_inputs();
    bus.mm_halt = 1'b1;
    #2;
    check("halt mem_busy", 32'(bus.mem_busy), 32'd0);
    step();
    check("halt set", 32'(bus.halt), 32'd1);
    nop_inputs();
    bus.mm_RegWEN   = 1'b1;
    bus.mm_MemtoReg = 2'd0;
    bus.mm_rd       = 5'd9;
    bus.mm_dREN     = 1'b1;
    bus.mm_ALUOut   = 32'h0000_0055;
    for (int c = 0; c < 5; c++) begin
      #2;
      check($sformatf("halt c%0d mem_busy", c), 32'(bus.mem_busy), 32'd0);
      check($sformatf("halt c%0d dmemREN", c), 32'(bus.dmemREN), 32'd0);
      step();
      check($sformatf("halt c%0d wb_RegWEN", c), 32'(bus.wb_RegWEN), 32'd0);
      check($sformatf("halt c%0d sticky", c), 32'(bus.halt), 32'd1);
    end
    $display("halt: halt=%0b dmemREN=%0b", bus.halt, bus.dmemREN);

`ifdef MEM_TIMEOUT_EN
    nop_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("timeout halt cleared", 32'(bus.halt), 32'd0);
    bus.mm_RegWEN   = 1'b1;
    bus.mm_MemtoReg = 2'd1;
    bus.mm_rd       = 5'd6;
    mem_op("timeout", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 99, 32'h0, 4, 4, 0,
           32'h0000_0200, 32'h0);
    check("timeout flag", 32'(bus.mem_timeout), 32'd1);
    check("timeout wb_RegWEN", 32'(bus.wb_RegWEN), 32'd0);
    check("timeout dmemREN after", 32'(bus.dmemREN), 32'd0);
    nop_inputs();
    step();
    check("timeout sticky", 32'(bus.mem_timeout), 32'd1);
`else
    check("mem_timeout tied", 32'(bus.mem_timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
